// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and default geometry for the direct-mapped write-back data cache.
`default_nettype none

package dcache_pkg;

  localparam int DEF_INDEX_BITS  = 6;
  localparam int DEF_OFFSET_BITS = 2;
  localparam int TAG_BITS        = 32 - DEF_INDEX_BITS - DEF_OFFSET_BITS - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } dcache_state_t;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } line_meta_t;

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// dcache_line_store: word-addressed line data array, one write port and two combinational read ports.
`default_nettype none

module dcache_line_store #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [31:0]       cpu_rdata,
  input  logic [ADDR_W-1:0] wb_raddr,
  output logic [31:0]       wb_rdata
);

  logic [31:0] words [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) words[waddr] <= wdata;
  end

  assign cpu_rdata = words[cpu_raddr];
  assign wb_rdata  = words[wb_raddr];

endmodule

`default_nettype wire

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with a word-serial memory port.
`default_nettype none

module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS  = DEF_INDEX_BITS,
  parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        read_enable,
  input  logic        write_enable,
  output logic        miss,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int TAG_W = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES = 1 << INDEX_BITS;
  localparam int LA_W  = INDEX_BITS + OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] CNT_ONE  = 1;
  localparam logic [OFFSET_BITS-1:0] CNT_LAST = '1;
  localparam logic [OFFSET_BITS-1:0] CNT_ZERO = '0;

  logic [TAG_W-1:0]       tag;
  logic [INDEX_BITS-1:0]  index;
  logic [OFFSET_BITS-1:0] offset;
  logic                   addr_unused;

  assign offset      = addr[OFFSET_BITS+1:2];
  assign index       = addr[LA_W+1:OFFSET_BITS+2];
  assign tag         = addr[31:LA_W+2];
  assign addr_unused = ^addr[1:0];

  line_meta_t             meta [LINES];
  dcache_state_t          state;
  logic [OFFSET_BITS-1:0] cnt;
  logic [OFFSET_BITS-1:0] cnt_next;
  logic [TAG_W-1:0]       victim_tag;
  logic [TAG_W-1:0]       fill_tag;
  logic [INDEX_BITS-1:0]  line_idx;

  logic req, hit, ack, cnt_last;

  assign req      = read_enable | write_enable;
  assign hit      = meta[index].valid & (meta[index].tag == tag);
  assign miss     = req & ((state != IDLE) | ~hit);
  assign ack      = mem_ack & mem_req;
  assign cnt_next = cnt + CNT_ONE;
  assign cnt_last = (cnt == CNT_LAST);

  // The writeback read port looks one word ahead so mem_wdata can be registered with mem_addr.
  logic [INDEX_BITS-1:0]  wb_line;
  logic [OFFSET_BITS-1:0] wb_word;
  logic [31:0]            wb_rdata;

  always_comb begin
    wb_line = line_idx;
    wb_word = cnt;
    if (state == IDLE) begin
      wb_line = index;
      wb_word = CNT_ZERO;
    end else if (state == WRITEBACK && ack) begin
      wb_word = cnt_next;
    end
  end

  logic            st_we;
  logic [LA_W-1:0] st_waddr;
  logic [31:0]     st_wdata;

  assign st_we    = ~rst & (((state == IDLE) & write_enable & hit) | ((state == REFILL) & ack));
  assign st_waddr = (state == REFILL) ? {line_idx, cnt} : {index, offset};
  assign st_wdata = (state == REFILL) ? mem_rdata : wdata;

  dcache_line_store #(.ADDR_W(LA_W)) u_store (
    .clk       (clk),
    .we        (st_we),
    .waddr     (st_waddr),
    .wdata     (st_wdata),
    .cpu_raddr ({index, offset}),
    .cpu_rdata (rdata),
    .wb_raddr  ({wb_line, wb_word}),
    .wb_rdata  (wb_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= CNT_ZERO;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      for (int i = 0; i < LINES; i++) begin
        meta[i].valid <= 1'b0;
        meta[i].dirty <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            line_idx   <= index;
            victim_tag <= meta[index].tag;
            fill_tag   <= tag;
            cnt        <= CNT_ZERO;
            mem_req    <= 1'b1;
            // The line is invalid from here until the refill completes, so an abort leaves no stale hit.
            meta[index].valid <= 1'b0;
            meta[index].dirty <= 1'b0;
            if (meta[index].valid && meta[index].dirty) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {meta[index].tag, index, CNT_ZERO, 2'b00};
              mem_wdata <= wb_rdata;
            end else begin
              state    <= REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {tag, index, CNT_ZERO, 2'b00};
            end
          end else if (write_enable && hit) begin
            meta[index].dirty <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (ack) begin
            if (cnt_last) begin
              state    <= REFILL;
              cnt      <= CNT_ZERO;
              mem_we   <= 1'b0;
              mem_addr <= {fill_tag, line_idx, CNT_ZERO, 2'b00};
            end else begin
              cnt       <= cnt_next;
              mem_addr  <= {victim_tag, line_idx, cnt_next, 2'b00};
              mem_wdata <= wb_rdata;
            end
          end
        end
        REFILL: begin
          if (ack) begin
            cnt <= cnt_next;
            if (cnt_last) begin
              state                <= IDLE;
              mem_req              <= 1'b0;
              meta[line_idx].valid <= 1'b1;
              meta[line_idx].dirty <= 1'b0;
              meta[line_idx].tag   <= fill_tag;
            end else begin
              mem_addr <= {fill_tag, line_idx, cnt_next, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
